// File: rtl/pc_loop_seq.sv
// ============================================================================
// Module      : pc_loop_seq
// Description : Program counter and sequencer with a hardware loop stack for
//               nested zero-overhead loops and an absolute jump. Optional
//               macro PC_STALL_EN adds a stall input that freezes RUN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_loop_seq #(
  parameter int AW    = 8,
  parameter int CW    = 8,
  parameter int LW    = 4,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
`ifdef PC_STALL_EN
  input  logic          stall,
`endif
  input  logic          enable,
  input  logic          loop_start,
  input  logic [CW-1:0] loop_cnt,
  input  logic [LW-1:0] loop_len,
  input  logic          jump,
  input  logic [AW-1:0] jump_addr,
  output logic [AW-1:0] addr,
  output logic          addr_valid,
  output logic          loop_active,
  output logic [2:0]    loop_level,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        r_state, w_state_nx;
  logic [AW-1:0] r_addr, w_addr_nx;
  logic [2:0]    r_sp, w_sp_nx;
  logic          r_err, w_err_nx;

  logic [AW-1:0] r_lstart [DEPTH];
  logic [AW-1:0] r_lend   [DEPTH];
  logic [CW-1:0] r_lcnt   [DEPTH];

  logic [AW-1:0] w_top_start, w_top_end;
  logic [CW-1:0] w_top_cnt;
  logic [AW-1:0] w_len_ext, w_push_end, w_inc;
  logic          w_push, w_dec, w_stall, w_req, w_step;

`ifdef PC_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  // Top-of-stack is entry r_sp-1; a one-hot mux avoids a variable array index.
  always_comb begin
    w_top_start = '0;
    w_top_end   = '0;
    w_top_cnt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_sp == 3'(i + 1)) begin
        w_top_start = r_lstart[i];
        w_top_end   = r_lend[i];
        w_top_cnt   = r_lcnt[i];
      end
    end
  end

  assign w_len_ext  = AW'(loop_len);
  assign w_inc      = r_addr + AW'(1);
  assign w_push_end = r_addr + w_len_ext;

  // Leaving IDLE/PAUSE performs a sequencing step with loop/jump requests masked,
  // so a pause at a loop end still wraps back to the loop start on resume.
  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_sp_nx    = r_sp;
    w_err_nx   = r_err;
    w_push     = 1'b0;
    w_dec      = 1'b0;
    w_req      = (r_state == RUN);
    w_step     = enable && !(w_req && w_stall);

    unique case (r_state)
      IDLE:    if (enable) w_state_nx = RUN;
      RUN:     if (!enable) w_state_nx = PAUSE;
      PAUSE:   if (enable) w_state_nx = RUN;
      default: w_state_nx = IDLE;
    endcase

    if (w_step) begin
      if (w_req && jump) begin
        w_addr_nx = jump_addr;
        w_sp_nx   = 3'd0;
      end else if (w_req && loop_start) begin
        if (loop_cnt == '0 || loop_len == '0) begin
          w_addr_nx = w_push_end + AW'(1);
        end else if (r_sp == 3'(DEPTH)) begin
          w_err_nx  = 1'b1;
          w_addr_nx = w_inc;
        end else begin
          w_push    = 1'b1;
          w_sp_nx   = r_sp + 3'd1;
          w_addr_nx = w_inc;
          if (r_sp != 3'd0 && w_push_end >= w_top_end) w_err_nx = 1'b1;
        end
      end else if (r_sp != 3'd0 && r_addr == w_top_end) begin
        if (w_top_cnt > CW'(1)) begin
          w_addr_nx = w_top_start;
          w_dec     = 1'b1;
        end else begin
          w_sp_nx   = r_sp - 3'd1;
          w_addr_nx = w_inc;
        end
      end else begin
        w_addr_nx = w_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_sp    <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_sp    <= w_sp_nx;
      r_err   <= w_err_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && r_sp == 3'(i)) begin
          r_lstart[i] <= w_inc;
          r_lend[i]   <= w_push_end;
          r_lcnt[i]   <= loop_cnt;
        end else if (w_dec && r_sp == 3'(i + 1)) begin
          r_lcnt[i] <= r_lcnt[i] - CW'(1);
        end
      end
    end
  end

  assign addr        = r_addr;
  assign addr_valid  = (r_state == RUN);
  assign loop_level  = r_sp;
  assign loop_active = (r_sp != 3'd0);
  assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_loop_seq.sv
// ============================================================================
// Module      : tb_pc_loop_seq
// Description : Self-checking bench for pc_loop_seq (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_loop_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stall = 1'b0;
  logic       enable = 1'b0;
  logic       loop_start = 1'b0;
  logic [7:0] loop_cnt = '0;
  logic [3:0] loop_len = '0;
  logic       jump = 1'b0;
  logic [7:0] jump_addr = '0;
  logic [7:0] addr;
  logic       addr_valid;
  logic       loop_active;
  logic [2:0] loop_level;
  logic       err;

  pc_loop_seq dut (
    .clk        (clk),
    .rst        (rst),
`ifdef PC_STALL_EN
    .stall      (stall),
`endif
    .enable     (enable),
    .loop_start (loop_start),
    .loop_cnt   (loop_cnt),
    .loop_len   (loop_len),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .addr       (addr),
    .addr_valid (addr_valid),
    .loop_active(loop_active),
    .loop_level (loop_level),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [2:0] lvl;
    logic       v;
    logic       e;
  } exp_t;

  typedef struct {
    logic       r, en, ls;
    logic [7:0] cnt;
    logic [3:0] len;
    logic       j;
    logic [7:0] ja;
    logic [7:0] ea;
    logic [2:0] el;
    logic       ev, ee;
  } vec_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic step(input logic r, input logic en, input logic ls,
                      input logic [7:0] cnt, input logic [3:0] len,
                      input logic j, input logic [7:0] ja,
                      input logic [7:0] ea, input logic [2:0] el,
                      input logic ev, input logic ee, input string nm);
    exp_t want, got;
    @(negedge clk);
    rst = r; enable = en; loop_start = ls; loop_cnt = cnt; loop_len = len;
    jump = j; jump_addr = ja;
    q.push_back('{a: ea, lvl: el, v: ev, e: ee});
    @(posedge clk);
    #1;
    got = '{a: addr, lvl: loop_level, v: addr_valid, e: err};
    n_checks++;
    if (q.size() == 0) begin
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      want = q.pop_front();
      if (got == want && loop_active == (want.lvl != 3'd0)) n_pass++;
      else $display("FAIL %s: got addr=%h lvl=%0d act=%b valid=%b err=%b, want addr=%h lvl=%0d act=%b valid=%b err=%b",
                    nm, got.a, got.lvl, loop_active, got.v, got.e,
                    want.a, want.lvl, (want.lvl != 3'd0), want.v, want.e);
    end
  endtask

  task automatic adv(input logic [7:0] ea, input logic [2:0] el, input logic ee, input string nm);
    step(1, 1, 0, 0, 0, 0, 0, ea, el, 1, ee, nm);
  endtask

  task automatic loopq(input logic [7:0] cnt, input logic [3:0] len,
                       input logic [7:0] ea, input logic [2:0] el, input logic ee, input string nm);
    step(1, 1, 1, cnt, len, 0, 0, ea, el, 1, ee, nm);
  endtask

  task automatic jmp(input logic [7:0] ja, input logic [7:0] ea, input string nm);
    step(1, 1, 0, 0, 0, 1, ja, ea, 0, 1, 0, nm);
  endtask

  vec_t vt[30];
  logic [7:0] na[15];
  logic [2:0] nl[15];
  logic [7:0] cur;

  initial begin
    //        r  en ls cnt len j  ja    ea   el ev ee
    vt[0]  = '{0, 0, 0, 0, 0, 0, 0,    0,   0, 0, 0};
    vt[1]  = '{0, 1, 0, 0, 0, 0, 0,    0,   0, 0, 0};
    vt[2]  = '{1, 1, 0, 0, 0, 0, 0,    1,   0, 1, 0};
    vt[3]  = '{1, 1, 0, 0, 0, 0, 0,    2,   0, 1, 0};
    vt[4]  = '{1, 1, 0, 0, 0, 0, 0,    3,   0, 1, 0};
    vt[5]  = '{1, 1, 0, 0, 0, 0, 0,    4,   0, 1, 0};
    vt[6]  = '{1, 1, 0, 0, 0, 0, 0,    5,   0, 1, 0};
    vt[7]  = '{1, 0, 0, 0, 0, 0, 0,    5,   0, 0, 0};
    vt[8]  = '{1, 0, 0, 0, 0, 0, 0,    5,   0, 0, 0};
    vt[9]  = '{1, 1, 0, 0, 0, 0, 0,    6,   0, 1, 0};
    vt[10] = '{0, 1, 0, 0, 0, 0, 0,    0,   0, 0, 0};
    vt[11] = '{1, 1, 0, 0, 0, 0, 0,    1,   0, 1, 0};
    vt[12] = '{1, 1, 0, 0, 0, 0, 0,    2,   0, 1, 0};
    vt[13] = '{1, 1, 0, 0, 0, 0, 0,    3,   0, 1, 0};
    vt[14] = '{1, 1, 1, 3, 2, 0, 0,    4,   1, 1, 0};
    vt[15] = '{1, 1, 0, 0, 0, 0, 0,    5,   1, 1, 0};
    vt[16] = '{1, 1, 0, 0, 0, 0, 0,    4,   1, 1, 0};
    vt[17] = '{1, 1, 0, 0, 0, 0, 0,    5,   1, 1, 0};
    vt[18] = '{1, 1, 0, 0, 0, 0, 0,    4,   1, 1, 0};
    vt[19] = '{1, 1, 0, 0, 0, 0, 0,    5,   1, 1, 0};
    vt[20] = '{1, 1, 0, 0, 0, 0, 0,    6,   0, 1, 0};
    vt[21] = '{1, 1, 0, 0, 0, 0, 0,    7,   0, 1, 0};
    vt[22] = '{1, 0, 0, 0, 0, 0, 0,    7,   0, 0, 0};
    vt[23] = '{1, 0, 1, 3, 2, 0, 0,    7,   0, 0, 0};
    vt[24] = '{1, 0, 0, 0, 0, 1, 8'h40, 7,  0, 0, 0};
    vt[25] = '{1, 1, 0, 0, 0, 0, 0,    8,   0, 1, 0};
    vt[26] = '{0, 0, 0, 0, 0, 0, 0,    0,   0, 0, 0};
    vt[27] = '{1, 0, 1, 3, 2, 1, 8'h40, 0,  0, 0, 0};
    vt[28] = '{1, 1, 0, 0, 0, 0, 0,    1,   0, 1, 0};
    vt[29] = '{1, 1, 0, 0, 0, 0, 0,    2,   0, 1, 0};

    for (int i = 0; i < 30; i++)
      step(vt[i].r, vt[i].en, vt[i].ls, vt[i].cnt, vt[i].len, vt[i].j, vt[i].ja,
           vt[i].ea, vt[i].el, vt[i].ev, vt[i].ee, $sformatf("table[%0d]", i));

    // Nested loops: outer at 2 (cnt 2, len 5), inner at 3 (cnt 2, len 2).
    na = '{3, 4, 5, 4, 5, 6, 7, 3, 4, 5, 4, 5, 6, 7, 8};
    nl = '{1, 2, 2, 2, 2, 1, 1, 1, 2, 2, 2, 2, 1, 1, 0};
    cur = 8'd2;
    for (int i = 0; i < 15; i++) begin
      if (i == 0)          loopq(2, 5, na[i], nl[i], 0, $sformatf("nested[%0d]", i));
      else if (cur == 8'd3) loopq(2, 2, na[i], nl[i], 0, $sformatf("nested[%0d]", i));
      else                 adv(na[i], nl[i], 0, $sformatf("nested[%0d]", i));
      cur = na[i];
    end

    // Stack overflow, then reset mid-loop clears everything including err.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "ovf_rst");
    adv(1, 0, 0, "ovf_run");
    loopq(5, 8, 2, 1, 0, "ovf_push1");
    loopq(5, 3, 3, 2, 0, "ovf_push2");
    loopq(2, 1, 4, 2, 1, "ovf_full");
    adv(5, 2, 1, "ovf_body");
    adv(3, 2, 1, "ovf_wrapback");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "midloop_rst");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "post_rst_idle");
    adv(1, 0, 0, "post_rst_run");

    // Inner end equal to parent end: err set, push still happens.
    loopq(2, 4, 2, 1, 0, "nest_outer");
    loopq(2, 3, 3, 2, 1, "nest_bad");
    adv(4, 2, 1, "nest_b4");
    adv(5, 2, 1, "nest_b5");
    adv(3, 2, 1, "nest_back");

    // Zero count / zero length skip, jump-vs-loop priority, jump mid-loop, wrap.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "z_rst");
    adv(1, 0, 0, "z_run");
    jmp(8'h0A, 8'h0A, "z_jump10");
    loopq(0, 4, 8'h0F, 0, 0, "z_cnt0");
    loopq(3, 0, 8'h10, 0, 0, "z_len0");
    step(1, 1, 1, 3, 2, 1, 8'h20, 8'h20, 0, 1, 0, "jump_beats_loop");
    loopq(5, 3, 8'h21, 1, 0, "jm_push");
    adv(8'h22, 1, 0, "jm_body");
    jmp(8'h40, 8'h40, "jm_jump");
    adv(8'h41, 0, 0, "jm_after");
    jmp(8'hFE, 8'hFE, "wrap_jump");
    adv(8'hFF, 0, 0, "wrap_ff");
    adv(8'h00, 0, 0, "wrap_00");
    loopq(1, 2, 8'h01, 1, 0, "cnt1_push");
    adv(8'h02, 1, 0, "cnt1_body");
    adv(8'h03, 0, 0, "cnt1_pop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
